demux1to4_16: RTL

DEMUX1TO4_16 -- requirements
Module: demux1to4_16

---
 rtl/demux1to4_16_pkg.sv | 10 +
 rtl/demux1to4_16_slot.sv | 36 +++
 rtl/demux1to4_16.sv | 53 +++++
 3 files changed

// File: rtl/demux1to4_16_pkg.sv
// demux1to4_16_pkg: shared channel indices and widths for the 1-to-4 demux
package demux1to4_16_pkg;
    localparam int CH_A          = 0;
    localparam int CH_B          = 1;
    localparam int CH_C          = 2;
    localparam int CH_D          = 3;
    localparam int N_CH          = 4;
    localparam int BUS_WIDTH_DEF = 16;
    localparam int CNT_W         = 8;
endpackage

// File: rtl/demux1to4_16_slot.sv
// demux_slot: one output channel -- holding register, valid flag and delivery counter
module demux_slot
    import demux1to4_16_pkg::*;
#(
    parameter int W = BUS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [W-1:0]     i_din,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic [CNT_W-1:0] o_cnt
);
    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;

    // load on accept, drop valid on delivery unless refilled, count deliveries (wrapping)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (i_load) r_data <= i_din;
            r_valid <= i_load | (r_valid & ~i_ready);
            if (r_valid & i_ready) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/demux1to4_16.sv
// demux1to4_16: routes a valid/ready input word to one of four registered output channels
module demux1to4_16
    import demux1to4_16_pkg::*;
#(
    parameter int bus_width = BUS_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           sel,
    input  logic [bus_width-1:0] din,
    output logic [N_CH-1:0]      out_valid,
    input  logic [N_CH-1:0]      out_ready,
    output logic [bus_width-1:0] dout_a,
    output logic [bus_width-1:0] dout_b,
    output logic [bus_width-1:0] dout_c,
    output logic [bus_width-1:0] dout_d,
    output logic [CNT_W-1:0]     cnt_a,
    output logic [CNT_W-1:0]     cnt_b,
    output logic [CNT_W-1:0]     cnt_c,
    output logic [CNT_W-1:0]     cnt_d
);
    logic [N_CH-1:0]      w_load;
    logic [bus_width-1:0] w_dout [N_CH];
    logic [CNT_W-1:0]     w_cnt  [N_CH];

    // the addressed slot can take a word if empty or emptying this cycle
    assign in_ready = ~out_valid[sel] | out_ready[sel];
    assign w_load   = (in_valid && in_ready) ? ({{(N_CH-1){1'b0}}, 1'b1} << sel) : '0;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        demux_slot #(.W(bus_width)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[i]),
            .i_din   (din),
            .i_ready (out_ready[i]),
            .o_valid (out_valid[i]),
            .o_data  (w_dout[i]),
            .o_cnt   (w_cnt[i])
        );
    end

    assign dout_a = w_dout[CH_A];
    assign dout_b = w_dout[CH_B];
    assign dout_c = w_dout[CH_C];
    assign dout_d = w_dout[CH_D];
    assign cnt_a  = w_cnt[CH_A];
    assign cnt_b  = w_cnt[CH_B];
    assign cnt_c  = w_cnt[CH_C];
    assign cnt_d  = w_cnt[CH_D];
endmodule
